// File: rtl/alu_issue_stage.sv
// -----------------------------------------------------------------------------
// alu_issue_stage
//
// Decode/issue stage for the non-forwarding RV32I pipeline. Decodes one
// instruction into an ALU opcode plus operand selection and holds the result
// in a valid/ready pipeline register that feeds the EX stage.
//
// Ports:
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_valid / o_ready    upstream handshake (o_ready = !o_valid || i_ready)
//   i_instr, i_pc        instruction word and its PC
//   i_rs1_data/rs2_data  register file read data (already resolved)
//   i_flush              kills the held bundle and any incoming instruction
//   o_valid / i_ready    downstream handshake to EX
//   o_operand_a/b        ALU operands
//   o_alu_op             ALU opcode (0 ADD .. 9 SRA, A pass b, F illegal)
//   o_rd_addr/o_rd_wren  destination register and write enable
//   o_illegal            instruction could not be decoded
//
// Optional feature (macro ALU_ISSUE_PERF_EN):
//   o_issue_cnt          number of accepted instructions (wraps)
//   o_stall_cnt          number of cycles with o_valid && !i_ready (wraps)
// -----------------------------------------------------------------------------
module alu_issue_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OP_W   = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [31:0]       i_instr,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_rs1_data,
    input  logic [DATA_W-1:0] i_rs2_data,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_operand_a,
    output logic [DATA_W-1:0] o_operand_b,
    output logic [OP_W-1:0]   o_alu_op,
    output logic [4:0]        o_rd_addr,
    output logic              o_rd_wren,
    output logic              o_illegal
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       o_issue_cnt,
    output logic [31:0]       o_stall_cnt
`endif
);

    // ALU opcodes
    localparam logic [OP_W-1:0] OpAdd  = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OpSub  = OP_W'(4'h1);
    localparam logic [OP_W-1:0] OpSlt  = OP_W'(4'h2);
    localparam logic [OP_W-1:0] OpSltu = OP_W'(4'h3);
    localparam logic [OP_W-1:0] OpXor  = OP_W'(4'h4);
    localparam logic [OP_W-1:0] OpOr   = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OpAnd  = OP_W'(4'h6);
    localparam logic [OP_W-1:0] OpSll  = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OpSrl  = OP_W'(4'h8);
    localparam logic [OP_W-1:0] OpSra  = OP_W'(4'h9);
    localparam logic [OP_W-1:0] OpPass = OP_W'(4'hA);
    localparam logic [OP_W-1:0] OpIll  = OP_W'(4'hF);

    // RV32I major opcodes
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;

    localparam logic [6:0] F7Zero = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    // Instruction fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;

    assign opcode = i_instr[6:0];
    assign rd     = i_instr[11:7];
    assign funct3 = i_instr[14:12];
    assign funct7 = i_instr[31:25];

    // Immediates
    logic [DATA_W-1:0] imm_i;
    logic [DATA_W-1:0] imm_s;
    logic [DATA_W-1:0] imm_b;
    logic [DATA_W-1:0] imm_u;
    logic [DATA_W-1:0] shamt;

    assign imm_i = {{(DATA_W-12){i_instr[31]}}, i_instr[31:20]};
    assign imm_s = {{(DATA_W-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
    assign imm_b = {{(DATA_W-13){i_instr[31]}}, i_instr[31], i_instr[7],
                    i_instr[30:25], i_instr[11:8], 1'b0};
    assign imm_u = {i_instr[31:12], 12'b0};
    assign shamt = {{(DATA_W-5){1'b0}}, i_instr[24:20]};

    // funct3 -> ALU op for the arithmetic/logic group; 001/101 are the shifts
    // and the alternate encodings (SUB/SRA) are resolved by the caller.
    function automatic logic [OP_W-1:0] funct3_op(input logic [2:0] f3);
        logic [OP_W-1:0] op;
        op = OpAdd;
        case (f3)
            3'b000:  op = OpAdd;
            3'b001:  op = OpSll;
            3'b010:  op = OpSlt;
            3'b011:  op = OpSltu;
            3'b100:  op = OpXor;
            3'b101:  op = OpSrl;
            3'b110:  op = OpOr;
            default: op = OpAnd;
        endcase
        return op;
    endfunction

    // Combinational decode
    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic [OP_W-1:0]   dec_op;
    logic              dec_wren;
    logic              dec_legal;

    always_comb begin
        dec_a     = '0;
        dec_b     = '0;
        dec_op    = OpAdd;
        dec_wren  = 1'b0;
        dec_legal = 1'b0;

        case (opcode)
            OpcOp: begin
                dec_a     = i_rs1_data;
                dec_b     = i_rs2_data;
                dec_wren  = 1'b1;
                dec_legal = 1'b1;
                dec_op    = funct3_op(funct3);
                if (funct3 == 3'b000 || funct3 == 3'b101) begin
                    // Only ADD/SUB and SRL/SRA have an alternate funct7
                    if (funct7 == F7Alt) begin
                        dec_op = (funct3 == 3'b000) ? OpSub : OpSra;
                    end else if (funct7 != F7Zero) begin
                        dec_legal = 1'b0;
                    end
                end else if (funct7 != F7Zero) begin
                    dec_legal = 1'b0;
                end
            end
            OpcOpImm: begin
                dec_a     = i_rs1_data;
                dec_b     = imm_i;
                dec_wren  = 1'b1;
                dec_legal = 1'b1;
                dec_op    = funct3_op(funct3);
                if (funct3 == 3'b001) begin
                    dec_b = shamt;
                    if (funct7 != F7Zero) begin
                        dec_legal = 1'b0;
                    end
                end else if (funct3 == 3'b101) begin
                    dec_b = shamt;
                    if (funct7 == F7Alt) begin
                        dec_op = OpSra;
                    end else if (funct7 != F7Zero) begin
                        dec_legal = 1'b0;
                    end
                end
            end
            OpcLui: begin
                dec_op    = OpPass;
                dec_b     = imm_u;
                dec_wren  = 1'b1;
                dec_legal = 1'b1;
            end
            OpcAuipc: begin
                dec_a     = i_pc;
                dec_b     = imm_u;
                dec_wren  = 1'b1;
                dec_legal = 1'b1;
            end
            OpcJal, OpcJalr: begin
                // The ALU produces the link value; the jump target is computed elsewhere
                dec_a     = i_pc;
                dec_b     = DATA_W'(4);
                dec_wren  = 1'b1;
                dec_legal = 1'b1;
            end
            OpcLoad: begin
                dec_a     = i_rs1_data;
                dec_b     = imm_i;
                dec_wren  = 1'b1;
                dec_legal = 1'b1;
            end
            OpcStore: begin
                dec_a     = i_rs1_data;
                dec_b     = imm_s;
                dec_legal = 1'b1;
            end
            OpcBranch: begin
                dec_a     = i_pc;
                dec_b     = imm_b;
                dec_legal = 1'b1;
            end
            default: begin
                dec_legal = 1'b0;
            end
        endcase

        if (!dec_legal) begin
            dec_op   = OpIll;
            dec_a    = '0;
            dec_b    = '0;
            dec_wren = 1'b0;
        end

        // x0 is never written
        if (rd == 5'd0) begin
            dec_wren = 1'b0;
        end
    end

    // Pipeline register
    logic valid_q;
    logic accept;

    assign o_ready = !valid_q || i_ready;
    assign accept  = i_valid && o_ready && !i_flush;
    assign o_valid = valid_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            o_operand_a <= '0;
            o_operand_b <= '0;
            o_alu_op    <= '0;
            o_rd_addr   <= '0;
            o_rd_wren   <= 1'b0;
            o_illegal   <= 1'b0;
        end else if (i_flush) begin
            // Data fields are left stale; only the valid bit matters after a kill
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q     <= 1'b1;
            o_operand_a <= dec_a;
            o_operand_b <= dec_b;
            o_alu_op    <= dec_op;
            o_rd_addr   <= rd;
            o_rd_wren   <= dec_wren;
            o_illegal   <= !dec_legal;
        end else if (i_ready) begin
            valid_q <= 1'b0;
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_issue_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (accept) begin
                o_issue_cnt <= o_issue_cnt + 32'd1;
            end
            if (valid_q && !i_ready) begin
                o_stall_cnt <= o_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Scoreboard bench for alu_issue_stage: the driver pushes the expected bundle
// of every accepted instruction into a queue, and an independent monitor
// compares the DUT outputs against the queue head whenever o_valid is high.
// Optional counters are checked when ALU_ISSUE_PERF_EN is defined.
// -----------------------------------------------------------------------------
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        wren;
        logic        ill;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_operand_a;
    logic [31:0] o_operand_b;
    logic [3:0]  o_alu_op;
    logic [4:0]  o_rd_addr;
    logic        o_rd_wren;
    logic        o_illegal;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] o_issue_cnt;
    logic [31:0] o_stall_cnt;
`endif

    alu_issue_stage #(
        .DATA_W(32),
        .OP_W  (4)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_instr    (i_instr),
        .i_pc       (i_pc),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .i_flush    (i_flush),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_operand_a(o_operand_a),
        .o_operand_b(o_operand_b),
        .o_alu_op   (o_alu_op),
        .o_rd_addr  (o_rd_addr),
        .o_rd_wren  (o_rd_wren),
        .o_illegal  (o_illegal)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .o_issue_cnt(o_issue_cnt),
        .o_stall_cnt(o_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          m_valid = 1'b0;
    int unsigned m_issue = 0;
    int unsigned m_stall = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode written straight from the instruction-set rules
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc_v,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm_i;
        logic [31:0] imm_s;
        logic [31:0] imm_b;
        logic [31:0] imm_u;
        logic [31:0] sh;
        bit          ok;
        opc   = ins[6:0];
        f3    = ins[14:12];
        f7    = ins[31:25];
        imm_i = 32'($signed(ins[31:20]));
        imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        imm_u = {ins[31:12], 12'h000};
        sh    = 32'(ins[24:20]);
        ok    = 1'b1;
        e.rd  = ins[11:7];
        e.wren = 1'b1;
        e.ill = 1'b0;
        e.op  = 4'h0;
        e.a   = 32'h0;
        e.b   = 32'h0;
        case (opc)
            7'h33: begin
                e.a = r1;
                e.b = r2;
                case ({f7, f3})
                    {7'h00, 3'd0}: e.op = 4'h0;
                    {7'h20, 3'd0}: e.op = 4'h1;
                    {7'h00, 3'd1}: e.op = 4'h7;
                    {7'h00, 3'd2}: e.op = 4'h2;
                    {7'h00, 3'd3}: e.op = 4'h3;
                    {7'h00, 3'd4}: e.op = 4'h4;
                    {7'h00, 3'd5}: e.op = 4'h8;
                    {7'h20, 3'd5}: e.op = 4'h9;
                    {7'h00, 3'd6}: e.op = 4'h5;
                    {7'h00, 3'd7}: e.op = 4'h6;
                    default:       ok = 1'b0;
                endcase
            end
            7'h13: begin
                e.a = r1;
                if (f3 == 3'd1) begin
                    e.b  = sh;
                    e.op = 4'h7;
                    ok   = (f7 == 7'h00);
                end else if (f3 == 3'd5) begin
                    e.b = sh;
                    if (f7 == 7'h00) e.op = 4'h8;
                    else if (f7 == 7'h20) e.op = 4'h9;
                    else ok = 1'b0;
                end else begin
                    e.b = imm_i;
                    case (f3)
                        3'd0:    e.op = 4'h0;
                        3'd2:    e.op = 4'h2;
                        3'd3:    e.op = 4'h3;
                        3'd4:    e.op = 4'h4;
                        3'd6:    e.op = 4'h5;
                        default: e.op = 4'h6;
                    endcase
                end
            end
            7'h37: begin e.op = 4'hA; e.b = imm_u; end
            7'h17: begin e.a = pc_v; e.b = imm_u; end
            7'h6F, 7'h67: begin e.a = pc_v; e.b = 32'd4; end
            7'h03: begin e.a = r1; e.b = imm_i; end
            7'h23: begin e.a = r1; e.b = imm_s; e.wren = 1'b0; end
            7'h63: begin e.a = pc_v; e.b = imm_b; e.wren = 1'b0; end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.op = 4'hF;
            e.a = 32'h0;
            e.b = 32'h0;
            e.wren = 1'b0;
            e.ill = 1'b1;
        end
        if (e.rd == 5'd0) e.wren = 1'b0;
        return e;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            4'h0:    return a + b;
            4'h1:    return a - b;
            4'h2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'h3:    return (a < b) ? 32'd1 : 32'd0;
            4'h4:    return a ^ b;
            4'h5:    return a | b;
            4'h6:    return a & b;
            4'h7:    return a << s;
            4'h8:    return a >> s;
            4'h9:    return 32'($signed(a) >>> s);
            4'hA:    return b;
            default: return 32'h0;
        endcase
    endfunction

    // One clock of stimulus; model state advances by the handshake rules
    task automatic drive(input bit v, input logic [31:0] ins, input logic [31:0] pc_v,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input bit fl, input bit rdy);
        bit acc;
        @(negedge clk);
        i_valid    = v;
        i_instr    = ins;
        i_pc       = pc_v;
        i_rs1_data = r1;
        i_rs2_data = r2;
        i_flush    = fl;
        i_ready    = rdy;
        #1;
        chk("o_valid", 32'(o_valid), 32'(m_valid));
        chk("o_ready", 32'(o_ready), 32'(!m_valid || rdy));
        acc = v && (!m_valid || rdy) && !fl;
        if (m_valid && !rdy) m_stall++;
        if (acc) begin
            sb_q.push_back(ref_decode(ins, pc_v, r1, r2));
            m_issue++;
        end
        if (fl) m_valid = 1'b0;
        else if (acc) m_valid = 1'b1;
        else if (rdy) m_valid = 1'b0;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_a"}, o_operand_a, 32'd0);
        chk({tag, "_b"}, o_operand_b, 32'd0);
        chk({tag, "_op"}, 32'(o_alu_op), 32'd0);
        chk({tag, "_rd"}, 32'(o_rd_addr), 32'd0);
        chk({tag, "_wren"}, 32'(o_rd_wren), 32'd0);
        chk({tag, "_ill"}, 32'(o_illegal), 32'd0);
    endtask

    // Asynchronous reset in the middle of a cycle, away from any clock edge
    task automatic reset_mid();
        @(negedge clk);
        #3;
        i_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk_zero_outputs("rst_mid");
        sb_q.delete();
        m_valid = 1'b0;
        m_issue = 0;
        m_stall = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: compare the presented bundle with the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && o_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = sb_q[0];
                    chk("operand_a", o_operand_a, e.a);
                    chk("operand_b", o_operand_b, e.b);
                    chk("alu_op", 32'(o_alu_op), 32'(e.op));
                    chk("rd_addr", 32'(o_rd_addr), 32'(e.rd));
                    chk("rd_wren", 32'(o_rd_wren), 32'(e.wren));
                    chk("illegal", 32'(o_illegal), 32'(e.ill));
                    // Consumed by EX, or killed by a flush
                    if (i_ready || i_flush) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    localparam logic [31:0] InsAdd  = 32'h002081B3;
    localparam logic [31:0] InsSrai = 32'h40935293;
    localparam logic [31:0] InsLui  = 32'hA5FFF0B7;
    localparam logic [31:0] InsAddi = 32'h00A08113;

    logic [6:0] opc_tab [10];

    initial begin
        logic [31:0] ins;
        logic [6:0]  f7;
        opc_tab = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h23, 7'h63, 7'h00};

        rst        = 1'b1;
        i_valid    = 1'b0;
        i_instr    = 32'h0;
        i_pc       = 32'h0;
        i_rs1_data = 32'h0;
        i_rs2_data = 32'h0;
        i_flush    = 1'b0;
        i_ready    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_zero_outputs("rst");
        rst = 1'b0;

        // add x3,x1,x2
        drive(1'b1, InsAdd, 32'h100, 32'd5, 32'd7, 1'b0, 1'b1);
        // srai x5,x6,9 and its ALU result
        drive(1'b1, InsSrai, 32'h104, 32'hFB77BFF6, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        chk("srai_alu", alu_ref(o_alu_op, o_operand_a, o_operand_b), 32'hFFFDBBDF);

        // Backpressure two cycles, then LUI accepted as EX frees the slot
        drive(1'b1, InsAdd, 32'h108, 32'd1, 32'd2, 1'b0, 1'b0);
        drive(1'b1, InsAdd, 32'h108, 32'd1, 32'd2, 1'b0, 1'b0);
        drive(1'b1, InsLui, 32'h10C, 32'd0, 32'd0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Flush kills both the held and the incoming instruction
        drive(1'b1, InsAddi, 32'h200, 32'd9, 32'd0, 1'b0, 1'b1);
        drive(1'b1, InsAdd, 32'h204, 32'd3, 32'd4, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Illegal encodings
        drive(1'b1, 32'hFFFFFFFF, 32'h300, 32'd1, 32'd1, 1'b0, 1'b1);
        drive(1'b1, 32'h02209093, 32'h304, 32'd1, 32'd1, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Reset while a bundle is stalled, then a normal issue
        drive(1'b1, InsAdd, 32'h400, 32'd11, 32'd12, 1'b0, 1'b1);
        drive(1'b1, InsLui, 32'h404, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, InsLui, 32'h404, 32'd0, 32'd0, 1'b0, 1'b0);
        reset_mid();
        drive(1'b1, InsAdd, 32'h500, 32'd21, 32'd22, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ins = $urandom;
            ins[6:0] = opc_tab[$urandom_range(0, 9)];
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = ins[31:25];
            endcase
            ins[31:25] = f7;
            if ($urandom_range(0, 15) == 0) ins[11:7] = 5'd0;
            drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom, $urandom,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end

        repeat (3) drive(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
`ifdef ALU_ISSUE_PERF_EN
        chk("issue_cnt", o_issue_cnt, m_issue);
        chk("stall_cnt", o_stall_cnt, m_stall);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/issue stage that drives the ALU's i_operand_a, i_operand_b and i_alu_op.
- Decodes an RV32I instruction into the 4-bit ALU opcode plus operand selection.
- Registers the result in a valid/ready pipeline register that feeds the EX stage.
- Targets the non-forwarding pipeline: operand data arrives already read from the register file, and flush comes from branch resolution.

Parameters:
DATA_W, 32, operand/PC width (only 32 supported)
OP_W, 4, ALU opcode width

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  asynchronous active-high reset
i_valid  in  1  upstream instruction valid
o_ready  out  1  stage can accept an instruction
i_instr  in  32  RV32I instruction word
i_pc  in  32  instruction PC
i_rs1_data  in  32  rs1 register value
i_rs2_data  in  32  rs2 register value
i_flush  in  1  kill held and incoming instruction
o_valid  out  1  issued bundle valid
i_ready  in  1  EX stage accepts bundle
o_operand_a  out  32  to ALU i_operand_a
o_operand_b  out  32  to ALU i_operand_b
o_alu_op  out  4  to ALU i_alu_op
o_rd_addr  out  5  destination register
o_rd_wren  out  1  destination write enable
o_illegal  out  1  instruction not decodable

Behaviour:
- ALU opcodes (fixed): 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, A pass operand_b, F illegal.
- Reset (async assert, sync release): o_valid=0; all data outputs 0; o_illegal=0.
- Handshake:
  - o_ready = !o_valid || i_ready (combinational).
  - Accept = i_valid && o_ready && !i_flush.
  - On accept, the decoded bundle registers at the next edge and o_valid=1. Latency is 1 cycle.
  - When o_valid && i_ready && !accept, o_valid clears to 0.
  - When o_valid && !i_ready, every output holds bit-stable.
- Flush: i_flush=1 at an edge forces o_valid=0 and drops any incoming instruction. Flush has priority over accept and over hold. Data outputs may keep stale values.
- Decode by opcode[6:0]:
  - 0110011 R-type: a=rs1, b=rs2. funct3/funct7 mapping:
    - 000/0000000 ADD; 000/0100000 SUB
    - 001 SLL; 010 SLT; 011 SLTU; 100 XOR
    - 101/0000000 SRL; 101/0100000 SRA
    - 110 OR; 111 AND
    - funct7 must be 0000000 except for SUB and SRA; any other funct7 is illegal.
  - 0010011 I-ALU: a=rs1, b=imm_i (sign-extended). Same funct3 map with funct3=000 giving ADD.
    - Shifts use b={27'b0,instr[24:20]}.
    - SLLI needs instr[31:25]=0000000. SRLI/SRAI need 0000000/0100000. Otherwise illegal.
  - 0110111 LUI: op A, a=0, b={instr[31:12],12'b0}.
  - 0010111 AUIPC: ADD, a=pc, b=imm_u.
  - 1101111 JAL / 1100111 JALR: ADD, a=pc, b=4 (link value).
  - 0000011 LOAD: ADD, a=rs1, b=imm_i.
  - 0100011 STORE: ADD, a=rs1, b=imm_s, rd_wren=0.
  - 1100011 BRANCH: ADD, a=pc, b=imm_b (target), rd_wren=0.
  - Any other opcode is illegal.
- Illegal result: op F, a=b=0, rd_wren=0, o_illegal=1. The bundle is still issued with o_valid=1.
- o_rd_addr = instr[11:7]. o_rd_wren is forced to 0 when rd=0.

Optional Feature:
ALU_ISSUE_PERF_EN:
- Defined: adds ports o_issue_cnt (out, 32, count of accepted instructions) and o_stall_cnt (out, 32, count of cycles with o_valid && !i_ready). Both reset to 0, wrap at 2^32, and are not affected by flush.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset: assert i_rst while o_valid=1 and i_ready=0 -> o_valid=0 and all outputs 0 immediately. After release, the first accept issues normally.
2. i_instr=0x002081B3 (add x3,x1,x2), rs1=5, rs2=7 -> next cycle o_valid=1, op=0, a=5, b=7, rd=3, rd_wren=1, illegal=0.
3. i_instr=0x40935293 (srai x5,x6,9), rs1=0xFB77BFF6 -> op=9, a=0xFB77BFF6, b=9. The ALU output checks as 0xFFFDBBDF.
4. Backpressure: hold i_ready=0 for 2 cycles with o_valid=1 -> o_ready=0 and outputs stable. Raise i_ready with i_valid=1 and LUI 0xA5FFF0B7 -> accepted that cycle; next cycle op=A, b=0xA5FFF000, rd=1.
5. i_flush=1 with i_valid=1 and o_valid=1 -> next cycle o_valid=0 and the instruction is not issued. With PERF_EN, o_issue_cnt does not increment.
6. i_instr=0xFFFFFFFF -> op=F, o_illegal=1, rd_wren=0, o_valid=1. Also check i_instr=0x02209093 (slli with bad funct7) -> illegal.
